// File: rtl/key_pulse_tx_pkg.sv
// Shared definitions for the key pulse transmitter: FSM encoding, idle pin level,
// and the millisecond-to-cycles helper also used by the receive-side debouncer.
package key_pulse_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_GAP  = 2'd2,
    ST_FIN  = 2'd3
  } state_t;

  localparam logic KEY_IDLE = 1'b1;

  function automatic int unsigned ms_cyc(input int unsigned clk_freq);
    return clk_freq / 1000;
  endfunction

endpackage

// File: rtl/key_pulse_tx_cycle_timer.sv
// Loadable one-shot down-counter; o_expire is high in the last cycle of a loaded interval.
// Load wins over clear; an idle (zero) counter never expires.
module key_pulse_tx_cycle_timer (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        i_load,
  input  logic [31:0] i_load_val,
  input  logic        i_clear,
  output logic        o_expire
);

  logic [31:0] r_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 32'd1;
    end
  end

  // A load of N gives N cycles of count N..1, expiring on the cycle holding 1.
  assign o_expire = (r_cnt == 32'd1);

endmodule

// File: rtl/key_pulse_tx.sv
// Bursts of N active-low key pulses (LOW_CYC low, GAP_CYC high each); 1-cycle accept latency.
// Requests while busy are dropped; abort releases the pin on the next edge without done.
module key_pulse_tx
  import key_pulse_tx_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 100000000,
  parameter int unsigned LOW_MS   = 30,
  parameter int unsigned GAP_MS   = 30,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_i,
  input  logic [CNT_W-1:0] count_i,
  input  logic             abort_i,
  output logic             key_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam logic [31:0] LOW_CYC = 32'(ms_cyc(CLK_FREQ) * LOW_MS);
  localparam logic [31:0] GAP_CYC = 32'(ms_cyc(CLK_FREQ) * GAP_MS);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_rem;
  logic             r_key;
  logic             r_busy;
  logic             r_done;
  logic             w_load;
  logic [31:0]      w_load_val;
  logic             w_clear;
  logic             w_latch;
  logic             w_dec;
  logic             w_expire;
  logic             w_key_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;

  key_pulse_tx_cycle_timer u_timer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_clear    (w_clear),
    .o_expire   (w_expire)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Abort is checked before timer expiry so it wins a same-cycle collision.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_load_val  = LOW_CYC;
    w_clear     = 1'b0;
    w_latch     = 1'b0;
    w_dec       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req_i && !abort_i) begin
          if (count_i != '0) begin
            w_state_nxt = ST_LOW;
            w_load      = 1'b1;
            w_latch     = 1'b1;
          end else begin
            w_state_nxt = ST_FIN;
          end
        end
      end
      ST_LOW: begin
        if (abort_i) begin
          w_state_nxt = ST_IDLE;
          w_clear     = 1'b1;
        end else if (w_expire) begin
          w_state_nxt = ST_GAP;
          w_load      = 1'b1;
          w_load_val  = GAP_CYC;
          w_dec       = 1'b1;
        end
      end
      ST_GAP: begin
        if (abort_i) begin
          w_state_nxt = ST_IDLE;
          w_clear     = 1'b1;
        end else if (w_expire) begin
          if (r_rem != '0) begin
            w_state_nxt = ST_LOW;
            w_load      = 1'b1;
          end else begin
            w_state_nxt = ST_FIN;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_key_nxt  = (w_state_nxt == ST_LOW) ? ~KEY_IDLE : KEY_IDLE;
    w_busy_nxt = (w_state_nxt == ST_LOW) || (w_state_nxt == ST_GAP);
    w_done_nxt = (w_state_nxt == ST_FIN);
  end

  // Outputs are registered from the next state so the pad sees a clean flop.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_key  <= KEY_IDLE;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_rem  <= '0;
    end else begin
      r_key  <= w_key_nxt;
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
      if (w_latch) begin
        r_rem <= count_i;
      end else if (w_clear) begin
        r_rem <= '0;
      end else if (w_dec && (r_rem != '0)) begin
        r_rem <= r_rem - 1'b1;
      end
    end
  end

  assign key_o  = r_key;
  assign busy_o = r_busy;
  assign done_o = r_done;

endmodule
